fft_out_reorder: RTL and testbench
==================================

# fft_out_reorder

Output reorder stage placed directly downstream of the parallel FFT core. It accepts the core's four complex output lanes (`fftOut0_up`, `fftOut0_down`, `fftOut1_up`, `fftOut1_down`, 15-bit I/Q each) in bit-reversed order. It re-emits each frame on four lanes in natural bin order. A ping-pong register bank lets one frame be written while the previous one is read, so sustained throughput is one 4-sample row per cycle.

## Interface
- `NBITS`, 15: bits per real/imag component; each lane is `NBITS*2` wide, with imag in the upper half and real in the lower half, as in the FFT core.
- `N`, 128: FFT points per frame; power of two, ≥8. Rows per frame R = N/4. LOG2N = log2(N).

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low; clears all state.
- `in_valid`  in  1  the four input lanes carry one row this cycle.
- `in_sof`  in  1  first row of a frame; only sampled when `in_valid`=1.
- `in0_up`, `in0_down`, `in1_up`, `in1_down`  in  NBITS*2 each  lanes j=0..3.
- `out_valid`  out  1  the output lanes carry one naturally ordered row.
- `out_sof`  out  1  first output row of a frame.
- `out0_up`, `out0_down`, `out1_up`, `out1_down`  out  NBITS*2 each  lanes k=0..3.

## Operation
- Input index mapping: at frame row t (0..R-1), lane j carries bin `bitrev_LOG2N(4t+j)`.
- Output index mapping: at output row r, lane k carries bin 4r+k.
- Storage: two banks (0/1), each holding N entries of NBITS*2 flops. The write pointer is `wbank`, `wrow` (0..R-1). Each bank has a `full[b]` flag.
- Write side: on `in_valid`=1, lane j is stored at address `bitrev(4*wrow+j)` of `wbank`, and `wrow` increments.
  - `in_valid` with `in_sof`=1 forces the row to be written as row 0. Any partial frame already in `wbank` is discarded; the bank is not switched.
  - When row R-1 is written, `full[wbank]` is set, `wbank` toggles, and `wrow` goes to 0.
  - Rows arriving without a preceding `in_sof` after reset are dropped until the first `in_sof`.
  - `in_valid`=0 holds all write state, so gaps inside a frame are allowed.
- Read FSM states are IDLE and READ.
  - IDLE→READ on the cycle after any `full[b]`=1. `rbank` is set to b and `rrow` to 0.
  - In READ, every cycle registers bank `rbank` entries 4*rrow..4*rrow+3 onto out lanes 0..3, asserts `out_valid`, and increments `rrow`. `out_sof` is asserted when `rrow`=0.
  - After `rrow`=R-1: clear `full[rbank]`. If `full[!rbank]` is set, continue in READ with the other bank at row 0 (back-to-back frames). Otherwise go to IDLE.
- Arithmetic: none. Data passes bit-exact; there is no sign extension or saturation.
- Collision-free by construction: filling a bank takes ≥R cycles and reading one takes exactly R cycles. A bank is therefore never written while it is being read.

## Timing
- Reset values: `out_valid`=0, `out_sof`=0, all out lanes 0, FSM=IDLE, `full`=0, `wbank`=0, `wrow`=0, `rbank`=0, `rrow`=0.
- Latency: if the last input row (t=R-1) is sampled at edge E, then `out_valid`/`out_sof` for row 0 are visible after edge E+2.
- With continuous input, output is continuous: R consecutive `out_valid` cycles per frame, with no bubble between frames.
- Simultaneous events:
  - A bank completing while the FSM is in READ on the other bank: the new frame follows immediately after that bank's last row.
  - `in_sof` on the cycle a frame completes: cannot occur, because the row is either R-1 or a restart.
- `rst` asserted mid-frame or mid-read: immediate asynchronous clear. Partial frames are lost. Output resumes only after a new complete frame following `in_sof`.

## Configuration
- `FFT_REORDER_FRMCNT_EN`: when defined, adds output `frame_cnt` [15:0].
  - It resets to 0 and increments (wrapping at 65535→0) on every `out_sof` cycle.
  - Its value during a frame's rows equals the number of frames emitted before it, modulo 2^16.
- When undefined: the port and counter do not exist; all other behaviour is identical.

## Test plan
- Single frame, N=128: drive R=32 rows with lane j of row t real = bitrev7(4t+j), imag = 0, `in_sof` on row 0. Required: after edge E+2, 32 consecutive `out_valid` rows with lane k of row r real = 4r+k, and `out_sof` only on r=0.
- Back-to-back: 3 frames of continuous input with per-frame offsets 0/128/256 in the imag part (truncated to NBITS). Required: 96 contiguous `out_valid` cycles, correct natural order per frame, and `out_sof` at output cycles 0, 32 and 64.
- Gapped input: `in_valid` toggling 1/0 across one frame. Required: identical output to the single-frame test, starting 2 cycles after the last row.
- Restart: 10 rows, then `in_sof` and a full frame. Required: exactly one 32-row output frame containing only the second frame's data.
- Reset mid-read: pull `rst` low at output row 5. Required: `out_valid`=0 and lanes 0 immediately; no output until a new full frame follows `in_sof`.
- With `FFT_REORDER_FRMCNT_EN`: 3 frames. Required: `frame_cnt` = 0, 1, 2 during the respective frames.

Source files
------------

// File: rtl/fft_out_reorder.sv
// rtl/fft_out_reorder.sv - bit-reversed to natural order ping-pong reorder stage (option: FFT_REORDER_FRMCNT_EN)
module fft_out_reorder #(
    parameter int NBITS = 15,
    parameter int N     = 128
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic                 in_sof,
    input  logic [NBITS*2-1:0]   in0_up,
    input  logic [NBITS*2-1:0]   in0_down,
    input  logic [NBITS*2-1:0]   in1_up,
    input  logic [NBITS*2-1:0]   in1_down,
    output logic                 out_valid,
    output logic                 out_sof,
    output logic [NBITS*2-1:0]   out0_up,
    output logic [NBITS*2-1:0]   out0_down,
    output logic [NBITS*2-1:0]   out1_up,
    output logic [NBITS*2-1:0]   out1_down
`ifdef FFT_REORDER_FRMCNT_EN
    ,
    output logic [15:0]          frame_cnt
`endif
);

    localparam int W     = NBITS * 2;
    localparam int LOG2N = $clog2(N);
    localparam int R     = N / 4;
    localparam int RW    = LOG2N - 2;

    typedef enum logic {IDLE, READ} state_t;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = a[LOG2N-1-i];
        end
        return r;
    endfunction

    logic [W-1:0]  mem [2][N];
    logic [W-1:0]  in_lane [4];
    logic [1:0]    full;
    logic          armed;
    logic          wbank;
    logic [RW-1:0] wrow;
    logic          wr_en;
    logic          wr_last;
    logic [RW-1:0] wr_row;

    state_t        state, state_nxt;
    logic          rbank, rbank_nxt;
    logic [RW-1:0] rrow, rrow_nxt;
    logic          rd_done;

    assign in_lane[0] = in0_up;
    assign in_lane[1] = in0_down;
    assign in_lane[2] = in1_up;
    assign in_lane[3] = in1_down;

    // Rows before the first in_sof after reset are ignored; in_sof restarts the current bank at row 0.
    assign wr_en   = in_valid && (in_sof || armed);
    assign wr_row  = in_sof ? '0 : wrow;
    assign wr_last = wr_en && (wr_row == RW'(R - 1));

    // Write pointer: advance per accepted row, switch banks after the last row of a frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed <= 1'b0;
            wbank <= 1'b0;
            wrow  <= '0;
        end else if (wr_en) begin
            armed <= 1'b1;
            if (wr_last) begin
                wbank <= ~wbank;
                wrow  <= '0;
            end else begin
                wrow <= wr_row + RW'(1);
            end
        end
    end

    // Scatter each input lane to its bit-reversed slot so reads become linear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < N; i++) begin
                    mem[b][i] <= '0;
                end
            end
        end else if (wr_en) begin
            for (int j = 0; j < 4; j++) begin
                mem[wbank][bitrev({wr_row, j[1:0]})] <= in_lane[j];
            end
        end
    end

    // Bank-full flags: set by the writer on frame completion, cleared by the reader after its last row.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full <= 2'b00;
        end else begin
            if (rd_done) begin
                full[rbank] <= 1'b0;
            end
            if (wr_last) begin
                full[wbank] <= 1'b1;
            end
        end
    end

    // Read FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            rbank <= 1'b0;
            rrow  <= '0;
        end else begin
            state <= state_nxt;
            rbank <= rbank_nxt;
            rrow  <= rrow_nxt;
        end
    end

    // Read FSM next state: start on any full bank, chain straight into the other bank if it is ready.
    always_comb begin
        state_nxt = state;
        rbank_nxt = rbank;
        rrow_nxt  = rrow;
        rd_done   = 1'b0;
        case (state)
            IDLE: begin
                if (full[0]) begin
                    state_nxt = READ;
                    rbank_nxt = 1'b0;
                    rrow_nxt  = '0;
                end else if (full[1]) begin
                    state_nxt = READ;
                    rbank_nxt = 1'b1;
                    rrow_nxt  = '0;
                end
            end
            READ: begin
                rrow_nxt = rrow + RW'(1);
                if (rrow == RW'(R - 1)) begin
                    rd_done  = 1'b1;
                    rrow_nxt = '0;
                    if (full[~rbank]) begin
                        rbank_nxt = ~rbank;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output register: one naturally ordered row per READ cycle; lanes hold their last value when idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out0_up   <= '0;
            out0_down <= '0;
            out1_up   <= '0;
            out1_down <= '0;
        end else begin
            out_valid <= (state == READ);
            out_sof   <= (state == READ) && (rrow == '0);
            if (state == READ) begin
                out0_up   <= mem[rbank][{rrow, 2'd0}];
                out0_down <= mem[rbank][{rrow, 2'd1}];
                out1_up   <= mem[rbank][{rrow, 2'd2}];
                out1_down <= mem[rbank][{rrow, 2'd3}];
            end
        end
    end

`ifdef FFT_REORDER_FRMCNT_EN
    logic [15:0] frames_done;

    // Frame counter: loaded with the count of earlier frames as each frame's first row goes out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frames_done <= 16'd0;
            frame_cnt   <= 16'd0;
        end else if (state == READ && rrow == '0) begin
            frame_cnt   <= frames_done;
            frames_done <= frames_done + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fft_out_reorder.sv
// tb/tb_fft_out_reorder.sv - directed self-checking bench for fft_out_reorder
module tb_fft_out_reorder;

    localparam int W = 30;

    typedef struct packed {
        logic [31:0]    cyc;
        logic           sof;
        logic [4*W-1:0] d;
        logic [15:0]    fc;
    } rec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_sof = 1'b0;
    logic [W-1:0] in0_up = '0, in0_down = '0, in1_up = '0, in1_down = '0;
    logic         out_valid, out_sof;
    logic [W-1:0] out0_up, out0_down, out1_up, out1_down;
    logic [15:0]  fc_obs;

    int   total = 0;
    int   bad = 0;
    int   cyc_cnt = 0;
    int   last_edge = 0;
    int   e0 = 0;
    int   fc_exp = 0;
    rec_t q[$];

`ifdef FFT_REORDER_FRMCNT_EN
    logic [15:0] frame_cnt;
    assign fc_obs = frame_cnt;
`else
    assign fc_obs = 16'd0;
`endif

    fft_out_reorder #(.NBITS(15), .N(128)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in0_up    (in0_up),
        .in0_down  (in0_down),
        .in1_up    (in1_up),
        .in1_down  (in1_down),
        .out_valid (out_valid),
        .out_sof   (out_sof),
        .out0_up   (out0_up),
        .out0_down (out0_down),
        .out1_up   (out1_up),
        .out1_down (out1_down)
`ifdef FFT_REORDER_FRMCNT_EN
        ,
        .frame_cnt (frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc_cnt++;
        #1;
        if (out_valid === 1'b1) begin
            q.push_back('{cyc: cyc_cnt, sof: out_sof,
                          d: {out1_down, out1_up, out0_down, out0_up}, fc: fc_obs});
        end
    end

    function automatic logic [6:0] br7(input int v);
        logic [6:0] r;
        for (int i = 0; i < 7; i++) r[i] = v[6-i];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_row(input logic sof, input logic [14:0] tag, input int t);
        in_valid = 1'b1;
        in_sof   = sof;
        in0_up   = {tag, 8'd0, br7(4*t+0)};
        in0_down = {tag, 8'd0, br7(4*t+1)};
        in1_up   = {tag, 8'd0, br7(4*t+2)};
        in1_down = {tag, 8'd0, br7(4*t+3)};
        @(posedge clk);
        #1;
        last_edge = cyc_cnt;
        in_valid  = 1'b0;
        in_sof    = 1'b0;
    endtask

    task automatic send_frame(input logic [14:0] tag, input logic gapped);
        for (int t = 0; t < 32; t++) begin
            send_row(t == 0, tag, t);
            if (gapped) idle(1);
        end
    endtask

    task automatic check_frame(input string name, input int base, input int first,
                               input logic [14:0] tag, input int fc);
        logic [4*W-1:0] exp;
        for (int r = 0; r < 32; r++) begin
            for (int k = 0; k < 4; k++) exp[k*W +: W] = {tag, 15'(4*r+k)};
            if (base + r < q.size()) begin
                chk($sformatf("%s_cyc_r%0d", name, r), q[base+r].cyc, first + r);
                chk($sformatf("%s_sof_r%0d", name, r), q[base+r].sof, (r == 0));
                chk($sformatf("%s_data_r%0d", name, r), q[base+r].d, exp);
`ifdef FFT_REORDER_FRMCNT_EN
                chk($sformatf("%s_fcnt_r%0d", name, r), q[base+r].fc, fc);
`endif
            end else begin
                chk($sformatf("%s_missing_r%0d", name, r), q.size(), base + r + 1);
            end
        end
    endtask

    initial begin
        // reset state
        #3;
        chk("rst_valid", out_valid, 0);
        chk("rst_sof", out_sof, 0);
        chk("rst_lanes", {out0_up, out0_down, out1_up, out1_down}, 0);
        idle(3);
        rst = 1'b1;

        // rows before the first in_sof are dropped
        for (int t = 0; t < 32; t++) send_row(1'b0, 15'd1, t);
        idle(40);
        chk("drop_count", q.size(), 0);

        // single frame
        q.delete();
        send_frame(15'd0, 1'b0);
        idle(40);
        chk("single_count", q.size(), 32);
        check_frame("single", 0, last_edge + 2, 15'd0, 0);

        // back-to-back three frames, counter starts fresh
        rst = 1'b0;
        idle(2);
        rst = 1'b1;
        q.delete();
        send_frame(15'd0, 1'b0);
        e0 = last_edge;
        send_frame(15'd128, 1'b0);
        send_frame(15'd256, 1'b0);
        idle(40);
        chk("b2b_count", q.size(), 96);
        check_frame("b2b0", 0, e0 + 2, 15'd0, 0);
        check_frame("b2b1", 32, e0 + 34, 15'd128, 1);
        check_frame("b2b2", 64, e0 + 66, 15'd256, 2);
        fc_exp = 3;

        // gapped input
        q.delete();
        send_frame(15'd5, 1'b1);
        idle(40);
        chk("gap_count", q.size(), 32);
        check_frame("gap", 0, last_edge + 2, 15'd5, fc_exp);
        fc_exp++;

        // restart after 10 rows
        q.delete();
        for (int t = 0; t < 10; t++) send_row(t == 0, 15'd7, t);
        send_frame(15'd9, 1'b0);
        idle(40);
        chk("restart_count", q.size(), 32);
        check_frame("restart", 0, last_edge + 2, 15'd9, fc_exp);

        // reset during output row 5
        q.delete();
        send_frame(15'd3, 1'b0);
        idle(7);
        chk("midread_valid", out_valid, 1);
        chk("midread_row5", out0_up, {15'd3, 15'd20});
        rst = 1'b0;
        #1;
        chk("rstread_valid", out_valid, 0);
        chk("rstread_sof", out_sof, 0);
        chk("rstread_lanes", {out0_up, out0_down, out1_up, out1_down}, 0);
        idle(2);
        rst = 1'b1;
        q.delete();
        for (int t = 0; t < 32; t++) send_row(1'b0, 15'd4, t);
        idle(40);
        chk("post_rst_drop", q.size(), 0);
        send_frame(15'd11, 1'b0);
        idle(40);
        chk("post_rst_count", q.size(), 32);
        check_frame("post_rst", 0, last_edge + 2, 15'd11, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
